// File: rtl/reg_share_arbiter_if.sv
// Bus bundle for reg_share_arbiter: request/write-data side and grant/ack/register side.
// The lock signal exists only when ARB_LOCK_EN is defined.
interface reg_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) ();
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       q;
    logic [IDX_W-1:0]        q_owner;
    logic                    busy;
`ifdef ARB_LOCK_EN
    logic                    lock;
`endif

    modport master (
        output req, wdata,
`ifdef ARB_LOCK_EN
        output lock,
`endif
        input  gnt, ack, q, q_owner, busy
    );

    modport slave (
        input  req, wdata,
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        output gnt, ack, q, q_owner, busy
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit register among N_REQ requesters (IDLE/GRANT/WRITE).
// Optional macro ARB_LOCK_EN adds a lock input that keeps re-granting the same requester.
module reg_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_share_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    w_q, w_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                busy_q, busy_d;

    logic                found_s;
    logic [IDX_W-1:0]    win_s;
    logic [DATA_W-1:0]   wsel_s;
    logic [IDX_W-1:0]    next_ptr_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner search: first set request starting at ptr and wrapping around.
    always_comb begin
        int   idx_v;
        logic hit_v;
        found_s = 1'b0;
        win_s   = '0;
        idx_v   = 0;
        hit_v   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = int'(ptr_q) + k;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            hit_v = 1'b0;
            for (int j = 0; j < N_REQ; j++) begin
                if (j == idx_v) begin
                    hit_v = bus.req[j];
                end else begin
                    hit_v = hit_v;
                end
            end
            if (!found_s && hit_v) begin
                found_s = 1'b1;
                win_s   = IDX_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Granted requester's write word and the pointer value that follows it.
    always_comb begin
        wsel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_q == IDX_W'(i)) begin
                wsel_s = bus.wdata[i*DATA_W +: DATA_W];
            end else begin
                wsel_s = wsel_s;
            end
        end
        if (int'(w_q) == N_REQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = w_q + IDX_W'(1);
        end
    end

    // Next-state and next-output logic; gnt/ack default low so each is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    w_d     = win_s;
                    gnt_d   = onehot(win_s);
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (bus.req[w_q]) begin
                    q_d     = wsel_s;
                    owner_d = w_q;
                    ack_d   = onehot(w_q);
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
`ifdef ARB_LOCK_EN
                if (bus.lock && bus.req[w_q]) begin
                    gnt_d   = onehot(w_q);
                    state_d = GRANT;
                end else begin
                    ptr_d   = next_ptr_s;
                    state_d = IDLE;
                end
`else
                ptr_d   = next_ptr_s;
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight grant without writing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.q       = q_q;
    assign bus.q_owner = owner_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: reset, single write, round-robin, abort, mid-grant reset, lock.
module tb_reg_share_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_share_arbiter_if #(.N_REQ(4), .DATA_W(8), .IDX_W(2)) bus ();

    reg_share_arbiter #(.N_REQ(4), .DATA_W(8), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic [7:0] qv, input logic [1:0] own, input logic b);
        chk({tag, ".gnt"},  32'(bus.gnt),     32'(g));
        chk({tag, ".ack"},  32'(bus.ack),     32'(a));
        chk({tag, ".q"},    32'(bus.q),       32'(qv));
        chk({tag, ".own"},  32'(bus.q_owner), 32'(own));
        chk({tag, ".busy"}, 32'(bus.busy),    32'(b));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] oh;
        logic [7:0] qe;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.req   = 4'b0000;
        bus.wdata = 32'h0000_0000;
`ifdef ARB_LOCK_EN
        bus.lock  = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk_all("reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        end

        // single request from requester 2
        bus.wdata = 32'h00A5_0000;
        bus.req   = 4'b0100;
        tick();
        chk_all("single.grant", 4'b0100, 4'b0000, 8'h00, 2'd0, 1'b1);
        tick();
        chk_all("single.write", 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_all("single.idle", 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b0);

        // all requesting: service order 0,1,2,3,0
        do_reset();
        chk_all("rr.reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        bus.wdata = 32'h1312_1110;
        bus.req   = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % 4);
            qe = 8'h10 + 8'(n % 4);
            tick();
            chk("rr.gnt", 32'(bus.gnt), 32'(oh));
            chk("rr.ack_low", 32'(bus.ack), 32'h0);
            tick();
            chk("rr.ack", 32'(bus.ack), 32'(oh));
            chk("rr.gnt_low", 32'(bus.gnt), 32'h0);
            chk("rr.q", 32'(bus.q), 32'(qe));
            chk("rr.own", 32'(bus.q_owner), 32'(n % 4));
            tick();
            chk("rr.idle_busy", 32'(bus.busy), 32'h0);
            chk("rr.idle_ack", 32'(bus.ack), 32'h0);
        end
        bus.req = 4'b0000;

        // requester 1 withdraws during GRANT
        do_reset();
        bus.wdata = 32'h0000_4433;
        bus.req   = 4'b0010;
        tick();
        chk_all("abort.grant", 4'b0010, 4'b0000, 8'h00, 2'd0, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_all("abort.idle", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_all("abort.stay", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        bus.req = 4'b0011;
        tick();
        chk_all("abort.next_grant", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1);
        tick();
        chk_all("abort.next_write", 4'b0000, 4'b0001, 8'h33, 2'd0, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk_all("abort.next_idle", 4'b0000, 4'b0000, 8'h33, 2'd0, 1'b0);

        // reset during GRANT for requester 3
        bus.wdata = 32'hFF00_0000;
        bus.req   = 4'b1000;
        tick();
        chk_all("rstg.grant", 4'b1000, 4'b0000, 8'h33, 2'd0, 1'b1);
        rst = 1'b1;
        tick();
        chk_all("rstg.reset", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        rst     = 1'b0;
        bus.req = 4'b0000;
        tick();
        chk_all("rstg.after", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        tick();
        chk_all("rstg.after2", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);

`ifdef ARB_LOCK_EN
        // lock held: requester 0 every 2 cycles, then round-robin moves to 3
        do_reset();
        bus.wdata = 32'hC300_005A;
        bus.req   = 4'b1001;
        bus.lock  = 1'b1;
        tick();
        chk_all("lock.g1", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b1);
        tick();
        chk_all("lock.a1", 4'b0000, 4'b0001, 8'h5A, 2'd0, 1'b1);
        tick();
        chk_all("lock.g2", 4'b0001, 4'b0000, 8'h5A, 2'd0, 1'b1);
        tick();
        chk_all("lock.a2", 4'b0000, 4'b0001, 8'h5A, 2'd0, 1'b1);
        tick();
        chk_all("lock.g3", 4'b0001, 4'b0000, 8'h5A, 2'd0, 1'b1);
        tick();
        chk_all("lock.a3", 4'b0000, 4'b0001, 8'h5A, 2'd0, 1'b1);
        bus.lock = 1'b0;
        tick();
        chk_all("lock.idle", 4'b0000, 4'b0000, 8'h5A, 2'd0, 1'b0);
        tick();
        chk_all("lock.g_other", 4'b1000, 4'b0000, 8'h5A, 2'd0, 1'b1);
        tick();
        chk_all("lock.a_other", 4'b0000, 4'b1000, 8'hC3, 2'd3, 1'b1);
        bus.req = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
